ff_scan_ctrl: RTL and testbench
===============================

FF_SCAN_CTRL -- requirements
Module: ff_scan_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: width of one scan beat.
REQ-002 SHALL have parameter CHAIN_BEATS, default 3: scan-chain length in beats, legal range 1..65535.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid, input, 1: checkpoint command request.
REQ-006 SHALL have port cmd_ready, output, 1: command accepted when cmd_valid and cmd_ready are both 1.
REQ-007 SHALL have port cmd_dir, input, 1: 0 = dump, 1 = restore; sampled on accept.
REQ-008 SHALL have port dout_valid, output, 1: dump beat available.
REQ-009 SHALL have port dout_ready, input, 1: consumer accepts dump beat.
REQ-010 SHALL have port dout_data, output, DATA_WIDTH: dump beat.
REQ-011 SHALL have port din_valid, input, 1: restore beat available.
REQ-012 SHALL have port din_ready, output, 1: controller accepts restore beat.
REQ-013 SHALL have port din_data, input, DATA_WIDTH: restore beat.
REQ-014 SHALL have port emu_halt, output, 1: DUT halt.
REQ-015 SHALL have port ff_scan, output, 1: DUT scan-shift enable.
REQ-016 SHALL have port ff_sdi, output, DATA_WIDTH: DUT scan input.
REQ-017 SHALL have port ff_sdo, input, DATA_WIDTH: DUT scan output.
REQ-018 SHALL have port done, output, 1: one-cycle pulse on command completion.

Function
REQ-019 SHALL implement states IDLE, PREP, DUMP, RESTORE, DONE.
REQ-020 SHALL drive cmd_ready = 1 only in IDLE; accept moves IDLE->PREP and latches cmd_dir.
REQ-021 SHALL drive emu_halt = 1 in every state except IDLE, so halt leads the first scan shift by exactly one cycle (PREP).
REQ-022 SHALL leave PREP after one cycle: to DUMP if latched dir = 0, to RESTORE if 1; beat counter cleared to 0.
REQ-023 In DUMP: dout_valid = 1, dout_data = ff_sdo, ff_sdi = ff_sdo (loopback), ff_scan = dout_ready; one beat transfers per cycle with dout_ready = 1.
REQ-024 In RESTORE: din_ready = 1, ff_sdi = din_data, ff_scan = din_valid; one beat transfers per cycle with din_valid = 1.
REQ-025 SHALL keep ff_scan = 0 and the counter unchanged on any cycle without a handshake; backpressure and bubbles only stall the chain.
REQ-026 SHALL increment the beat counter on each transfer; the transfer at count CHAIN_BEATS-1 moves to DONE.
REQ-027 DONE SHALL last one cycle with done = 1 and emu_halt = 1, then move to IDLE.
REQ-028 Outside DUMP/RESTORE, dout_valid, din_ready and ff_scan SHALL be 0, and ff_sdi SHALL equal ff_sdo.
REQ-029 A full dump SHALL leave DUT flip-flop state unchanged, because exactly CHAIN_BEATS loopback shifts rotate the chain once.
REQ-030 cmd_valid while busy SHALL be ignored; it is not queued.
REQ-031 Paths dout_ready->ff_scan and din_valid->ff_scan are combinational by design; all state is registered.
REQ-032 With CHAIN_BEATS = 1, each command SHALL take exactly one transfer.

Reset
REQ-033 rst_n low SHALL force IDLE, counter 0, and latched dir 0 immediately, with emu_halt, ff_scan, done, dout_valid and din_ready = 0 and cmd_ready = 1 after reset.
REQ-034 Reset asserted mid-scan SHALL abort the command without a done pulse; the DUT chain contents are then undefined and software must restore.

Structure
REQ-035 A shared package SHALL hold the state enum and the dump/restore direction constants.
REQ-036 Counter width SHALL be $clog2(CHAIN_BEATS+1).
REQ-037 The module SHALL be a single flat block with no sub-modules.

Verification
REQ-038 Dump, CHAIN_BEATS = 3, dout_ready held 1, DUT loaded with d1..d4: 3 beats in 3 consecutive cycles; done pulses 1 cycle later; DUT q outputs unchanged afterwards.
REQ-039 Dump with dout_ready toggling 1,0,0,1,0,1: ff_scan high only on ready cycles; beat sequence identical to REQ-038; done after the 3rd transfer.
REQ-040 Restore of the beats captured in REQ-038 into a DUT re-loaded with random data, din_valid gapped: q1..q4 equal the original d values after done.
REQ-041 Four dump/restore rounds with random data, matching the checkpoint round-trip flow: all compare; emu_halt low exactly in IDLE.
REQ-042 rst_n pulled low after beat 1 of 3: outputs go to reset values asynchronously; no done; a new command is accepted on the cycle after release.
REQ-043 cmd_valid held during an active restore: no second command starts; exactly one done per accepted command.

Source files
------------

// File: rtl/ff_scan_ctrl_pkg.sv
// Shared definitions for the flip-flop scan checkpoint controller:
// the controller state encoding and the dump/restore direction codes.
package ff_scan_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PREP    = 3'd1,
        ST_DUMP    = 3'd2,
        ST_RESTORE = 3'd3,
        ST_DONE    = 3'd4
    } scan_state_t;

    localparam logic DIR_DUMP    = 1'b0;
    localparam logic DIR_RESTORE = 1'b1;

endpackage

// File: rtl/ff_scan_ctrl.sv
// Flip-flop scan checkpoint controller.
// Halts the emulated design, then either streams its scan chain out as
// dump beats (looping each beat back in so the chain ends where it began)
// or shifts restore beats in. Handshake stalls simply hold the chain.
module ff_scan_ctrl #(
    parameter int DATA_WIDTH  = 64,
    parameter int CHAIN_BEATS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_dir,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [DATA_WIDTH-1:0] dout_data,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic [DATA_WIDTH-1:0] din_data,
    output logic                  emu_halt,
    output logic                  ff_scan,
    output logic [DATA_WIDTH-1:0] ff_sdi,
    input  logic [DATA_WIDTH-1:0] ff_sdo,
    output logic                  done
);

    import ff_scan_ctrl_pkg::*;

    localparam int CNT_W = $clog2(CHAIN_BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(CHAIN_BEATS - 1);

    scan_state_t      state;
    scan_state_t      state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             dir;
    logic             dir_next;
    logic             xfer;

    // A beat moves whenever the active side of the stream handshakes.
    assign xfer = ((state == ST_DUMP) && dout_ready) ||
                  ((state == ST_RESTORE) && din_valid);

    // State, beat counter and latched direction; reset aborts any command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            dir   <= DIR_DUMP;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            dir   <= dir_next;
        end
    end

    // Next-state logic: one prep cycle, CHAIN_BEATS transfers, one done cycle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        dir_next   = dir;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_next = ST_PREP;
                    dir_next   = cmd_dir;
                end
            end
            ST_PREP: begin
                cnt_next   = '0;
                state_next = (dir == DIR_RESTORE) ? ST_RESTORE : ST_DUMP;
            end
            ST_DUMP, ST_RESTORE: begin
                if (xfer) begin
                    cnt_next = cnt + CNT_W'(1);
                    if (cnt == LAST_BEAT) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs: halt whenever busy, scan only on a handshake, loopback otherwise.
    always_comb begin
        cmd_ready  = (state == ST_IDLE);
        emu_halt   = (state != ST_IDLE);
        done       = (state == ST_DONE);
        dout_valid = (state == ST_DUMP);
        din_ready  = (state == ST_RESTORE);
        dout_data  = ff_sdo;
        ff_sdi     = (state == ST_RESTORE) ? din_data : ff_sdo;
        ff_scan    = xfer;
    end

endmodule

// File: tb/tb_ff_scan_ctrl.sv
// Self-checking bench for ff_scan_ctrl. A behavioural scan chain stands in
// for the halted design; a cycle-level reference timeline and a beat
// scoreboard check every output, and chain contents are compared after
// each dump (must be unchanged) and restore (must match the checkpoint).
module tb_ff_scan_ctrl;

    import ff_scan_ctrl_pkg::*;

    localparam int DW      = 16;
    localparam int NB      = 3;
    localparam int TIMEOUT = 200;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_dir = 1'b0;
    logic          dout_valid;
    logic          dout_ready = 1'b0;
    logic [DW-1:0] dout_data;
    logic          din_valid = 1'b0;
    logic          din_ready;
    logic [DW-1:0] din_data = '0;
    logic          emu_halt;
    logic          ff_scan;
    logic [DW-1:0] ff_sdi;
    logic [DW-1:0] ff_sdo;
    logic          done;

    int checks = 0;
    int errors = 0;
    int done_count = 0;
    int cmds_completed = 0;

    always #5 clk = ~clk;

    ff_scan_ctrl #(.DATA_WIDTH(DW), .CHAIN_BEATS(NB)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
        .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
        .emu_halt(emu_halt), .ff_scan(ff_scan), .ff_sdi(ff_sdi), .ff_sdo(ff_sdo),
        .done(done)
    );

    // Behavioural scan chain of the halted design: beat 0 enters, beat NB-1 leaves.
    logic [DW-1:0] chain    [NB];
    logic [DW-1:0] load_val [NB];
    logic [DW-1:0] snap     [NB];
    logic          load_req = 1'b0;
    assign ff_sdo = chain[NB-1];

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < NB; i++) chain[i] <= load_val[i];
        end else if (ff_scan) begin
            chain[0] <= ff_sdi;
            for (int i = 1; i < NB; i++) chain[i] <= chain[i-1];
        end
    end

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference timeline: idle -> one prep cycle -> NB handshaked beats -> one done cycle.
    typedef enum {M_IDLE, M_PREP, M_XFER, M_DONE} m_phase_t;
    m_phase_t      m_phase = M_IDLE;
    logic          m_dir = 1'b0;
    int            m_left = 0;
    logic          mon_hs;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] captured[$];
    logic [DW-1:0] rbeats[$];

    // Monitor: compare every output on the falling edge, then advance the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_phase = M_IDLE;
            exp_q.delete();
            checkBit("rst_cmd_ready", cmd_ready, 1'b1);
            checkBit("rst_emu_halt", emu_halt, 1'b0);
            checkBit("rst_done", done, 1'b0);
            checkBit("rst_dout_valid", dout_valid, 1'b0);
            checkBit("rst_din_ready", din_ready, 1'b0);
            checkBit("rst_ff_scan", ff_scan, 1'b0);
        end else begin
            mon_hs = (m_phase == M_XFER) && (m_dir ? din_valid : dout_ready);
            checkBit("cmd_ready", cmd_ready, m_phase == M_IDLE);
            checkBit("emu_halt", emu_halt, m_phase != M_IDLE);
            checkBit("done", done, m_phase == M_DONE);
            checkBit("dout_valid", dout_valid, (m_phase == M_XFER) && !m_dir);
            checkBit("din_ready", din_ready, (m_phase == M_XFER) && m_dir);
            checkBit("ff_scan", ff_scan, mon_hs);
            checkOutput("ff_sdi", ff_sdi,
                        ((m_phase == M_XFER) && m_dir) ? din_data : ff_sdo);
            if (done) done_count++;
            if (mon_hs && !m_dir) begin
                captured.push_back(dout_data);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL dout_extra: got beat %0h expected no beat", dout_data);
                end else begin
                    checkOutput("dout_data", dout_data, exp_q.pop_front());
                end
            end
            case (m_phase)
                M_IDLE: if (cmd_valid) begin m_phase = M_PREP; m_dir = cmd_dir; end
                M_PREP: begin m_phase = M_XFER; m_left = NB; end
                M_XFER: if (mon_hs) begin
                    m_left--;
                    if (m_left == 0) m_phase = M_DONE;
                end
                M_DONE: m_phase = M_IDLE;
                default: m_phase = M_IDLE;
            endcase
        end
    end

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic loadRandom();
        for (int i = 0; i < NB; i++) load_val[i] = DW'($urandom);
        load_req = 1'b1;
        waitCycle();
        load_req = 1'b0;
    endtask

    task automatic takeSnapshot();
        for (int i = 0; i < NB; i++) snap[i] = chain[i];
    endtask

    task automatic checkChain(input string tag);
        for (int i = 0; i < NB; i++) checkOutput(tag, chain[i], snap[i]);
    endtask

    task automatic reportTimeout(input string tag);
        checks++;
        errors++;
        $display("[TB] FAIL %s_timeout: got no done expected done within %0d cycles", tag, TIMEOUT);
    endtask

    // Dump the chain: mode 0 = ready held, 1 = fixed 1,0,0,1,0,1 pattern, 2 = random.
    task automatic applyStimulus(input int mode);
        int             cyc;
        int             pidx;
        logic [5:0]     pat;
        pat = 6'b101001;
        captured.delete();
        takeSnapshot();
        for (int k = 0; k < NB; k++) exp_q.push_back(chain[NB-1-k]);
        cmd_dir   = DIR_DUMP;
        cmd_valid = 1'b1;
        waitCycle();
        cmd_valid = 1'b0;
        waitCycle();
        cyc  = 0;
        pidx = 0;
        while (!done && cyc < TIMEOUT) begin
            case (mode)
                0:       dout_ready = 1'b1;
                1:       dout_ready = pat[pidx % 6];
                default: dout_ready = 1'($urandom_range(0, 1));
            endcase
            pidx++;
            waitCycle();
            cyc++;
        end
        dout_ready = 1'b0;
        if (cyc >= TIMEOUT) reportTimeout("dump");
        else cmds_completed++;
        waitCycle();
        checkChain("dump_chain_kept");
    endtask

    // Restore rbeats with gapped din_valid; optionally hold cmd_valid while busy.
    task automatic runRestore(input bit hold_cmd);
        int cyc;
        int idx;
        bit hs;
        cmd_dir   = DIR_RESTORE;
        cmd_valid = 1'b1;
        waitCycle();
        cmd_valid = hold_cmd;
        waitCycle();
        cyc = 0;
        idx = 0;
        while (!done && cyc < TIMEOUT) begin
            din_valid = (idx < NB) && ($urandom_range(0, 2) != 0);
            din_data  = (idx < NB) ? rbeats[idx] : DW'($urandom);
            hs        = din_valid && din_ready;
            waitCycle();
            if (hs) idx++;
            cyc++;
        end
        din_valid = 1'b0;
        cmd_valid = 1'b0;
        if (cyc >= TIMEOUT) reportTimeout("restore");
        else cmds_completed++;
        waitCycle();
        checkChain("restore_chain");
    endtask

    logic [DW-1:0] orig [NB];

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        waitCycle();

        // Dump with ready held, then with a stalling ready pattern.
        loadRandom();
        applyStimulus(0);
        rbeats = captured;
        for (int i = 0; i < NB; i++) orig[i] = snap[i];
        applyStimulus(1);

        // Restore the first checkpoint into a scrambled chain.
        loadRandom();
        for (int i = 0; i < NB; i++) snap[i] = orig[i];
        runRestore(1'b0);

        // Round trips; one restore keeps cmd_valid asserted while busy.
        for (int r = 0; r < 4; r++) begin
            loadRandom();
            applyStimulus(2);
            rbeats = captured;
            for (int i = 0; i < NB; i++) orig[i] = snap[i];
            loadRandom();
            for (int i = 0; i < NB; i++) snap[i] = orig[i];
            runRestore(r == 1);
        end

        // Abort a dump after its first beat with an asynchronous reset.
        loadRandom();
        for (int k = 0; k < NB; k++) exp_q.push_back(chain[NB-1-k]);
        cmd_dir   = DIR_DUMP;
        cmd_valid = 1'b1;
        waitCycle();
        cmd_valid = 1'b0;
        waitCycle();
        dout_ready = 1'b1;
        waitCycle();
        #1;
        rst_n = 1'b0;
        #1;
        checkBit("abort_emu_halt", emu_halt, 1'b0);
        checkBit("abort_cmd_ready", cmd_ready, 1'b1);
        checkBit("abort_dout_valid", dout_valid, 1'b0);
        checkBit("abort_ff_scan", ff_scan, 1'b0);
        checkBit("abort_done", done, 1'b0);
        dout_ready = 1'b0;
        waitCycle();
        rst_n = 1'b1;
        applyStimulus(0);

        checkOutput("done_count", DW'(done_count), DW'(cmds_completed));
        checkOutput("leftover_beats", DW'(exp_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no completion expected finish before %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
